// File: rtl/druaga_load_ctrl.sv
// Download steering and core-reset sequencing between hps_io and the Druaga core.
// Routes ioctl writes to ROM/title/DIP targets, stretches core reset and checks ROM size.
module druaga_load_ctrl #(
  parameter logic [24:0] ROM_BYTES   = 25'h30000,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  input  logic        rst_req,
  output logic        rom_we,
  output logic [24:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [3:0]  tno,
  output logic [23:0] dsw,
  output logic        core_reset,
  output logic        rom_ok
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_HOLD,
    ST_RUN
  } state_t;

  localparam logic [15:0] HC_M1 = 16'(HOLD_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_hcnt;
  logic [15:0] w_hcnt_next;
  logic        r_core_reset;

  logic        r_dl_d;
  logic        r_live;
  logic        r_idx0;
  logic [24:0] r_acc_cnt;
  logic        r_rom_ok;

  logic        r_rom_we;
  logic [24:0] r_rom_addr;
  logic [7:0]  r_rom_data;
  logic [3:0]  r_tno;
  logic [23:0] r_dsw;

  logic        w_rise;
  logic        w_fall;
  logic        w_idx0_now;
  logic        w_rom_acc;
  logic        w_dip_wr;
  logic [24:0] w_acc_base;
  logic [24:0] w_acc_next;

  // r_live masks the first cycle after reset so a download already in progress
  // is not mistaken for a fresh start.
  assign w_rise     = r_live & ioctl_download & ~r_dl_d;
  assign w_fall     = ~ioctl_download & r_dl_d;
  assign w_idx0_now = (ioctl_index == 8'd0);
  assign w_rom_acc  = ioctl_wr & w_idx0_now & (ioctl_addr < ROM_BYTES);
  assign w_dip_wr   = ioctl_wr & (ioctl_index == 8'd254) & (ioctl_addr[24:2] == 23'd0);

  always_comb begin
    w_acc_base = (w_rise && w_idx0_now) ? '0 : r_acc_cnt;
    w_acc_next = w_acc_base;
    if (w_rom_acc && (w_acc_base != '1)) begin
      w_acc_next = w_acc_base + 25'd1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_hcnt_next = r_hcnt;
    if (ioctl_download) begin
      w_next = ST_LOAD;
    end else begin
      unique case (r_state)
        ST_LOAD: begin
          w_next      = ST_HOLD;
          w_hcnt_next = HC_M1;
        end
        ST_HOLD: begin
          if (rst_req) begin
            w_hcnt_next = HC_M1;
          end else if (r_hcnt == 16'd0) begin
            w_next = ST_RUN;
          end else begin
            w_hcnt_next = r_hcnt - 16'd1;
          end
        end
        ST_RUN: begin
          if (rst_req) begin
            w_next      = ST_HOLD;
            w_hcnt_next = HC_M1;
          end
        end
        default: begin
          w_next      = ST_HOLD;
          w_hcnt_next = HC_M1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_HOLD;
      r_hcnt       <= HC_M1;
      r_core_reset <= 1'b1;
    end else begin
      r_state      <= w_next;
      r_hcnt       <= w_hcnt_next;
      r_core_reset <= (w_next != ST_RUN);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_d    <= 1'b0;
      r_live    <= 1'b0;
      r_idx0    <= 1'b0;
      r_acc_cnt <= '0;
      r_rom_ok  <= 1'b0;
    end else begin
      r_dl_d    <= ioctl_download;
      r_live    <= 1'b1;
      r_acc_cnt <= w_acc_next;
      if (w_rise) begin
        r_idx0 <= w_idx0_now;
        if (w_idx0_now) begin
          r_rom_ok <= 1'b0;
        end
      end else if (w_fall && r_idx0) begin
        r_rom_ok <= (r_acc_cnt == ROM_BYTES);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_we   <= 1'b0;
      r_rom_addr <= '0;
      r_rom_data <= '0;
      r_tno      <= '0;
      r_dsw      <= '0;
    end else begin
      r_rom_we <= w_rom_acc;
      if (w_rom_acc) begin
        r_rom_addr <= ioctl_addr;
        r_rom_data <= ioctl_dout;
      end
      if (ioctl_wr && (ioctl_index == 8'd1)) begin
        r_tno <= ioctl_dout[3:0];
      end
      if (w_dip_wr) begin
        unique case (ioctl_addr[1:0])
          2'd0:    r_dsw[7:0]   <= ioctl_dout;
          2'd1:    r_dsw[15:8]  <= ioctl_dout;
          2'd2:    r_dsw[23:16] <= ioctl_dout;
          default: r_dsw        <= r_dsw;
        endcase
      end
    end
  end

  assign rom_we     = r_rom_we;
  assign rom_addr   = r_rom_addr;
  assign rom_data   = r_rom_data;
  assign tno        = r_tno;
  assign dsw        = r_dsw;
  assign core_reset = r_core_reset;
  assign rom_ok     = r_rom_ok;

endmodule
